// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selection and line levels.
// Used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data path of the UART transmitter: captured word, bit counter, last-bit flag
// and the data bit that will be on the line in the next cycle.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic                  active,
    output logic                  ser_done,
    output logic                  next_bit_c,
    output logic                  data_xor_c
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  shift;

    assign ser_done   = active && (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign shift      = active && !ser_done;
    assign data_xor_c = ^data_q;

    // Counter restarts when DATA is entered and stops at the last bit.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (shift) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign next_bit_c = data_q[cnt_d];

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load) begin
                data_q <= load_data;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: frames a parallel word as start, data (LSB first),
// optional parity and stop bit, one bit per clk cycle.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  ready,
    output logic                  tx_out,
    output logic                  busy
);

    import uart_pkg::*;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] PARITY = ST_PARITY;
    localparam logic [2:0] STOP   = ST_STOP;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       par_en_q;
    logic       par_typ_q;
    logic       accept;
    logic       ser_done;
    logic       next_bit_c;
    logic       data_xor_c;
    logic       parity_bit;
    logic       tx_d;
    logic       busy_d;

    assign ready      = (state_q == IDLE) || (state_q == STOP);
    assign accept     = data_valid && ready;
    assign parity_bit = data_xor_c ^ (par_typ_q == PAR_ODD);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_data  (p_data),
        .start      (state_q == START),
        .active     (state_q == DATA),
        .ser_done   (ser_done),
        .next_bit_c (next_bit_c),
        .data_xor_c (data_xor_c)
    );

    // Next state plus the line value and busy level of the state being entered.
    always_comb begin
        state_d = state_q;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b1;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = next_bit_c;
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = STOP_BIT;
            default: begin
                tx_d   = LINE_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_out    <= LINE_IDLE;
            busy      <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_out  <= tx_d;
            busy    <= busy_d;
            if (accept) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
            end
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial UART transmitter: accepts one parallel word per handshake and shifts it out as a frame on a single line. The frame is a start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and one stop bit. It is the transmit counterpart of the receive path's sampler, parity check and stop check. It runs in the TX clock domain, where one `clk` cycle equals one bit time.

## Interface
- DATA_WIDTH, 8, number of data bits per frame

- clk  in  1  TX bit clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- p_data  in  DATA_WIDTH  parallel word to send
- data_valid  in  1  p_data is valid; accepted only when `ready`
- par_en  in  1  1 = insert parity bit
- par_typ  in  1  0 = even parity, 1 = odd parity
- ready  out  1  block can accept a word this cycle (combinational from state)
- tx_out  out  1  serial line; idles high
- busy  out  1  registered; high while a frame is on the line

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance:**
  - `ready` = (state == IDLE) or (state == STOP).
  - `data_valid & ready` at an edge captures p_data, par_en and par_typ into internal registers.
  - Changes to inputs after capture do not affect the frame in flight.
- **Parity:** bit = ^data_q XOR par_typ_q, computed from the captured word only.
- **Transitions:**
  - IDLE→START on accept.
  - START→DATA after 1 cycle.
  - DATA→PARITY after DATA_WIDTH cycles if par_en_q, else DATA→STOP.
  - PARITY→STOP after 1 cycle.
  - STOP→START if accept in that cycle, else STOP→IDLE.
- **Line value per state:**
  - IDLE: 1
  - START: 0
  - DATA: data_q[bit_cnt], bit_cnt = 0…DATA_WIDTH−1
  - PARITY: parity bit
  - STOP: 1
- **Bit counter:** width $clog2(DATA_WIDTH); cleared on entering DATA; no wrap beyond DATA_WIDTH−1.
- **Output registering:** tx_out and busy are registered outputs with no combinational path from inputs. Each takes the value of the state the FSM is entering.
- **Ignored input:** data_valid while `ready`=0 is ignored; no queuing and no error flag.

## Timing
- **Reset values:**
  - reset high at any edge (including mid-frame): state IDLE, tx_out=1, busy=0, bit_cnt=0, captured registers 0.
  - The next frame may be accepted the cycle after reset deasserts.
- **Acceptance latency:** accept at edge k.
  - Start bit on tx_out from k+1.
  - Data bit i at k+2+i.
  - Parity (if enabled) at k+2+DATA_WIDTH.
  - Stop at k+2+DATA_WIDTH+par_en_q.
- **Frame length:** 10 cycles (DATA_WIDTH=8, no parity) or 11 cycles (with parity).
- **busy:** high for exactly the frame cycles; low from the cycle after the stop bit unless back-to-back.
- **Back-to-back:** a word accepted during the STOP cycle starts its start bit immediately after. There is no idle gap and busy stays high continuously.
- **Simultaneous reset and data_valid:** reset wins; the word is dropped.

## Structure
- **Shared package `uart_pkg`:**
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Parity type constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
  - Line levels LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - These are shared with the RX side.
- **Sub-module `uart_tx_serializer`:**
  - Owns data_q, the bit counter, a `ser_done` pulse on the last data bit, and the current serial bit.
  - The top holds the FSM, parity and the registered output mux.

## Test plan
- **Reset/idle:** reset 3 cycles then release, no valid → tx_out=1, busy=0, ready=1 held for 20 cycles.
- **No parity:** p_data=8'hA5, par_en=0 → tx_out over 10 cycles = 0,1,0,1,0,0,1,0,1,1; busy high exactly those 10 cycles.
- **Parity types:**
  - p_data=8'hA5, par_en=1, par_typ=0 → parity bit 0, 11-cycle frame.
  - Same with par_typ=1 → parity bit 1.
  - p_data=8'h01 even → parity 1.
- **Back-to-back:** send 8'h3C, then assert valid with 8'hC3 during the STOP cycle → second start bit directly follows stop, busy never drops.
  - valid pulsed mid-frame with 8'hFF → ignored, no extra frame.
- **Reset mid-frame:** reset at data bit 4 of 8'h55 → next cycle tx_out=1, busy=0.
  - A new 8'h0F is then sent correctly.
- **Input hold-off:** change p_data/par_typ one cycle after acceptance → transmitted bits match the captured values.
